bitrev_unscramble: RTL and testbench

BITREV_UNSCRAMBLE -- requirements
Module: bitrev_unscramble

---
 rtl/fft_accel_pkg.sv | 17 +
 rtl/bitrev_unscramble_if.sv | 32 +++
 rtl/bitrev_unscr_ram.sv | 22 ++
 rtl/bitrev_unscramble.sv | 125 ++++++++++++
 tb/tb_bitrev_unscramble.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_accel_pkg.sv
// Shared FFT accelerator helpers: frame length derivation and index bit reversal.
package fft_accel_pkg;

    localparam int unsigned MAX_K = 16;

    function automatic int unsigned frame_len(input int unsigned k);
        return 32'd1 << k;
    endfunction

    // Mirror all MAX_K bits, then shift so only the low k bits carry the reversed index.
    function automatic logic [MAX_K-1:0] bit_reverse(input logic [MAX_K-1:0] x, input int unsigned k);
        logic [MAX_K-1:0] r;
        r = {<<{x}};
        return r >> (MAX_K - k);
    endfunction

endpackage

// File: rtl/bitrev_unscramble_if.sv
// Stream bundle around the unscrambler: bit-reversed input side, natural-order output side.
// The last flag exists only when BITREV_UNSCR_LAST_EN is defined.
interface bitrev_unscramble_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    bank_full;
`ifdef BITREV_UNSCR_LAST_EN
    logic          last;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, bank_full
`ifdef BITREV_UNSCR_LAST_EN
        , input last
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, bank_full
`ifdef BITREV_UNSCR_LAST_EN
        , output last
`endif
    );
endinterface

// File: rtl/bitrev_unscr_ram.sv
// Ping-pong frame storage: one write port, one combinational read port; swap point for SRAM macros.
module bitrev_unscr_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bitrev_unscramble.sv
// Reorders bit-reversed frames of N=2^K samples into natural order using two ping-pong banks.
// Define BITREV_UNSCR_LAST_EN to add the last_o marker on natural index N-1.
module bitrev_unscramble
    import fft_accel_pkg::*;
#(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i,
    output logic [1:0]    bank_full_o
`ifdef BITREV_UNSCR_LAST_EN
    ,
    output logic          last_o
`endif
);
    localparam int N  = int'(frame_len(K));
    localparam int AW = K + 1;

    logic [K-1:0]  wr_cnt_reg;
    logic [K-1:0]  rd_cnt_reg;
    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic [1:0]    bank_full_reg;
    logic [1:0]    bank_full_next;
    logic [1:0]    bank_set;
    logic [1:0]    bank_clr;
    logic          valid_reg;
    logic [DW-1:0] data_reg;
`ifdef BITREV_UNSCR_LAST_EN
    logic          last_reg;
`endif

    logic          wr_fire;
    logic          wr_done;
    logic          rd_load;
    logic          rd_done;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    assign ready_o = !bank_full_reg[wr_bank_reg];
    assign wr_fire = valid_i && ready_o;
    assign wr_done = wr_fire && (wr_cnt_reg == K'(N - 1));
    // Output register refills whenever it is empty or being drained this cycle.
    assign rd_load = bank_full_reg[rd_bank_reg] && (ready_i || !valid_reg);
    assign rd_done = rd_load && (rd_cnt_reg == K'(N - 1));

    assign wr_addr = {wr_bank_reg, K'(bit_reverse(MAX_K'(wr_cnt_reg), K))};
    assign rd_addr = {rd_bank_reg, rd_cnt_reg};

    // Writer and reader always own different banks, so set and clear never collide.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi]       = wr_done && (wr_bank_reg == 1'(gi));
            assign bank_clr[gi]       = rd_done && (rd_bank_reg == 1'(gi));
            assign bank_full_next[gi] = bank_set[gi] || (bank_full_reg[gi] && !bank_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            bank_full_reg <= 2'b00;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
`ifdef BITREV_UNSCR_LAST_EN
            last_reg      <= 1'b0;
`endif
        end else begin
            bank_full_reg <= bank_full_next;
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + K'(1);
                if (wr_done) begin
                    wr_bank_reg <= !wr_bank_reg;
                end
            end
            if (rd_load) begin
                valid_reg  <= 1'b1;
                data_reg   <= rd_data;
                rd_cnt_reg <= rd_cnt_reg + K'(1);
`ifdef BITREV_UNSCR_LAST_EN
                last_reg   <= rd_done;
`endif
                if (rd_done) begin
                    rd_bank_reg <= !rd_bank_reg;
                end
            end else if (ready_i) begin
                valid_reg <= 1'b0;
`ifdef BITREV_UNSCR_LAST_EN
                last_reg  <= 1'b0;
`endif
            end
        end
    end

    assign valid_o     = valid_reg;
    assign data_o      = data_reg;
    assign bank_full_o = bank_full_reg;
`ifdef BITREV_UNSCR_LAST_EN
    assign last_o      = last_reg;
`endif

    bitrev_unscr_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_fire),
        .waddr (wr_addr),
        .wdata (data_i),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_bitrev_unscramble.sv
// Scoreboard bench for bitrev_unscramble with K=3; last_o is checked when BITREV_UNSCR_LAST_EN is defined.
module tb_bitrev_unscramble;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int N  = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    int   nat_order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    bitrev_unscramble_if #(.DW(DW)) bus ();

    always #5 clk = ~clk;

    bitrev_unscramble #(.K(K), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (bus.in_valid),
        .data_i      (bus.in_data),
        .ready_o     (bus.in_ready),
        .valid_o     (bus.out_valid),
        .data_o      (bus.out_data),
        .ready_i     (bus.out_ready),
        .bank_full_o (bus.bank_full)
`ifdef BITREV_UNSCR_LAST_EN
        , .last_o    (bus.last)
`endif
    );

    function automatic int tb_rev3(input int x);
        return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
    endfunction

    // Output monitor: pops the scoreboard on each output handshake and checks stall stability.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev;
`ifdef BITREV_UNSCR_LAST_EN
    logic          last_prev;
`endif
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== data_prev) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             bus.out_valid, bus.out_data, data_prev);
                end
`ifdef BITREV_UNSCR_LAST_EN
                checks++;
                if (bus.last !== last_prev) begin
                    errors++;
                    $display("FAIL hold_last: last=%b, required %b", bus.last, last_prev);
                end
`endif
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: data=%h, required no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data) begin
                        errors++;
                        $display("FAIL out_data: data=%h, required %h", bus.out_data, e.data);
                    end
`ifdef BITREV_UNSCR_LAST_EN
                    checks++;
                    if (bus.last !== e.last) begin
                        errors++;
                        $display("FAIL out_last: last=%b, required %b (data %h)", bus.last, e.last, e.data);
                    end
`endif
                end
                got_q.push_back(bus.out_data);
            end
            stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            data_prev  = bus.out_data;
`ifdef BITREV_UNSCR_LAST_EN
            last_prev  = bus.last;
`endif
        end
    end

    task automatic push_frame(input logic [DW-1:0] vals [N]);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{data: vals[tb_rev3(i)], last: (i == N - 1)});
        end
    endtask

    // Drive one sample; returns 1 time unit after the accepting edge.
    task automatic send(input logic [DW-1:0] v);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (bus.in_ready !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_o=%b, required 1 within 300 cycles", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic check_natural_frame(input string name);
        checks++;
        if (got_q.size() != N) begin
            errors++;
            $display("FAIL %s_count: outputs=%0d, required %0d", name, got_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q[i] !== DW'(nat_order[i])) begin
                    errors++;
                    $display("FAIL %s_order[%0d]: data=%0d, required %0d", name, i, got_q[i], nat_order[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bank_full !== 2'b00 || bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b full=%b data=%h ready=%b, required 0 00 0 1",
                     bus.out_valid, bus.bank_full, bus.out_data, bus.in_ready);
        end
`ifdef BITREV_UNSCR_LAST_EN
        checks++;
        if (bus.last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: last=%b, required 0", bus.last);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals [N];
        bus.out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < N; i++) vals[i] = DW'(i);
        push_frame(vals);
        for (int i = 0; i < N; i++) send(vals[i]);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_valid_early: valid=%b one cycle after last input, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL first_valid_t2: valid=%b data=%h, required 1 0", bus.out_valid, bus.out_data);
        end
        wait_drain();
        check_natural_frame("basic");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals [N];
        bus.out_ready = 1'b0;
        got_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) vals[i] = DW'(100 + 8 * f + i);
            push_frame(vals);
            for (int i = 0; i < N; i++) send(vals[i]);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(999);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.bank_full !== 2'b11) begin
            errors++;
            $display("FAIL both_full: ready=%b full=%b, required 0 11", bus.in_ready, bus.bank_full);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.bank_full !== 2'b11 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: ready=%b full=%b valid=%b, required 0 11 1",
                     bus.in_ready, bus.bank_full, bus.out_valid);
        end
`ifdef BITREV_UNSCR_LAST_EN
        checks++;
        if (bus.last !== 1'b0) begin
            errors++;
            $display("FAIL stall_last: last=%b on index 0, required 0", bus.last);
        end
`endif
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        checks++;
        if (got_q.size() != 2 * N) begin
            errors++;
            $display("FAIL backpressure_count: outputs=%0d, required %0d", got_q.size(), 2 * N);
        end
    endtask

    task automatic test_stall_random();
        logic [DW-1:0] vals [N];
        int done = 0;
        int guard = 0;
        got_q.delete();
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    for (int i = 0; i < N; i++) vals[i] = $urandom;
                    push_frame(vals);
                    for (int i = 0; i < N; i++) send(vals[i]);
                end
                done = 1;
            end
            begin
                while ((done == 0 || exp_q.size() != 0) && guard < 3000) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    guard++;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        checks++;
        if (got_q.size() != 4 * N) begin
            errors++;
            $display("FAIL random_count: outputs=%0d, required %0d", got_q.size(), 4 * N);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] vals [N];
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(DW'(50 + i));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        checks++;
        if (bus.bank_full !== 2'b00 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: full=%b valid=%b, required 00 0", bus.bank_full, bus.out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete();
        for (int i = 0; i < N; i++) vals[i] = DW'(i);
        push_frame(vals);
        for (int i = 0; i < N; i++) send(vals[i]);
        wait_drain();
        check_natural_frame("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end
endmodule
